// File: rtl/mips32_boot_loader.sv
// mips32_boot_loader
//   Byte-stream program loader in front of the MIPS32 core. It accepts a framed
//   stream (16-bit big-endian word count, then the payload words MSB first, then
//   an optional XOR checksum byte). Each 32-bit word goes out through a single
//   memory write port. The core is held until the whole image has been written.
//
//   Optional feature macro: MIPS32_BOOT_CHECKSUM_EN
//     defined   -> a trailing XOR byte over the length and payload bytes is
//                  required; a mismatch ends in ERR.
//     undefined -> no checksum state and no XOR logic.
//
// Ports
//   clk1       phase-1 clock; all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse; starts a load from IDLE, DONE or ERR
//   in_data    stream byte
//   in_valid   in_data valid
//   in_ready   loader accepts a byte this cycle
//   mem_we     one-cycle write strobe per assembled word
//   mem_addr   word address (BASE_ADDR + word index, truncated)
//   mem_wdata  assembled word
//   cpu_hold   1 = core halted with PC forced to BASE_ADDR
//   boot_done  image loaded, core released
//   boot_err   malformed image, core stays held
module mips32_boot_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              boot_done,
  output logic              boot_err
);

  localparam logic [31:0] CAP    = 32'((1 << ADDR_W) - BASE_ADDR);
  localparam logic [31:0] BASE_W = 32'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA,
`ifdef MIPS32_BOOT_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE, S_ERR
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  len_hi;
  logic [15:0] nwords;
  logic [16:0] idx;      // words written so far
  logic [1:0]  bcnt;     // byte position within the current word
  logic [23:0] sr;       // first three bytes of the current word
  logic [15:0] len_in;
  logic        acc, drained, start_ok;
`ifdef MIPS32_BOOT_CHECKSUM_EN
  logic [7:0]  csum;
  logic        last_byte;
  assign last_byte = (bcnt == 2'd3) && (idx + 17'd1 == {1'b0, nwords});
`endif

  assign len_in   = {len_hi, in_data};
  assign drained  = (idx == {1'b0, nwords});
  assign acc      = in_valid && in_ready;
  assign start_ok = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

  assign cpu_hold  = (state != S_DONE);
  assign boot_done = (state == S_DONE);
  assign boot_err  = (state == S_ERR);

  // Without the checksum the last word is followed by one drain cycle in DATA
  // (ready low, final mem_we visible) so that the core is released only after
  // the final write has landed.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_LEN_HI, S_LEN_LO: in_ready = 1'b1;
      S_DATA:             in_ready = !drained;
`ifdef MIPS32_BOOT_CHECKSUM_EN
      S_CHK:              in_ready = 1'b1;
`endif
      default:            in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_LEN_HI;
      S_LEN_HI: if (acc) state_nx = S_LEN_LO;
      S_LEN_LO: if (acc) begin
        if (len_in == 16'd0)
`ifdef MIPS32_BOOT_CHECKSUM_EN
          state_nx = S_CHK;
`else
          state_nx = S_DONE;
`endif
        else if (32'(len_in) > CAP) state_nx = S_ERR;
        else                        state_nx = S_DATA;
      end
`ifdef MIPS32_BOOT_CHECKSUM_EN
      S_DATA:   if (acc && last_byte) state_nx = S_CHK;
      S_CHK:    if (acc) state_nx = (in_data == csum) ? S_DONE : S_ERR;
`else
      S_DATA:   if (drained) state_nx = S_DONE;
`endif
      S_DONE, S_ERR: if (start) state_nx = S_LEN_HI;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len_hi    <= '0;
      nwords    <= '0;
      idx       <= '0;
      bcnt      <= '0;
      sr        <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef MIPS32_BOOT_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state  <= state_nx;
      mem_we <= 1'b0;
      if (start_ok) begin
        idx  <= '0;
        bcnt <= '0;
`ifdef MIPS32_BOOT_CHECKSUM_EN
        csum <= '0;
`endif
      end
      if (acc) begin
`ifdef MIPS32_BOOT_CHECKSUM_EN
        csum <= csum ^ in_data;
`endif
        case (state)
          S_LEN_HI: len_hi <= in_data;
          S_LEN_LO: nwords <= len_in;
          S_DATA: begin
            sr   <= {sr[15:0], in_data};
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= ADDR_W'(BASE_W + 32'(idx));
              mem_wdata <= {sr, in_data};
              idx       <= idx + 17'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/mips32_boot_loader.md
# mips32_boot_loader

Byte-stream program loader sitting directly upstream of the MIPS32 pipeline. Accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them into the processor's instruction/data memory through a single write port. Holds the core stalled (`cpu_hold`) until a complete, well-formed image has been written, then releases it so execution starts from `BASE_ADDR`.

## Interface
- `ADDR_W`, 10: memory word-address width; image capacity is 2**ADDR_W words.
- `BASE_ADDR`, 0: word address of the first loaded instruction.
- `clk1`  input  1  processor phase-1 clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- `in_data`  input  8  stream byte.
- `in_valid`  input  1  `in_data` valid.
- `in_ready`  output  1  loader accepts a byte this cycle.
- `mem_we`  output  1  memory write strobe, one cycle per word.
- `mem_addr`  output  ADDR_W  word address for `mem_we`.
- `mem_wdata`  output  32  word for `mem_we`.
- `cpu_hold`  output  1  1 = processor held halted with PC forced to `BASE_ADDR`.
- `boot_done`  output  1  level; image loaded and core released.
- `boot_err`  output  1  level; malformed image, core stays held.

## Operation
- Frame: 2 length bytes N (big-endian, word count), then N×4 payload bytes (each word MSB first), then 1 checksum byte if `BOOT_CHECKSUM_EN`.
- A byte is accepted on a cycle with `in_valid && in_ready`.
- States: IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR.
- IDLE → LEN_HI on `start`. LEN_HI → LEN_LO after one byte. LEN_LO → DATA after one byte if 0 < N ≤ 2**ADDR_W − BASE_ADDR; → CHK (or DONE without macro) if N = 0; → ERR if N exceeds capacity.
- DATA: 2-bit byte counter, 32-bit shift register. On the 4th byte, register the word; the word index increments; after word N−1, → CHK (or DONE).
- CHK: one byte; equals running XOR of all length and payload bytes → DONE, else → ERR.
- DONE: `cpu_hold`=0, `boot_done`=1. ERR: `cpu_hold`=1, `boot_err`=1, `in_ready`=0.
- `start` in DONE/ERR restarts: clears flags, reasserts `cpu_hold` the next cycle, → LEN_HI. `start` in any loading state is ignored.
- `in_ready` = 1 only in LEN_HI, LEN_LO, DATA, CHK.
- `mem_addr` = BASE_ADDR + word index, truncated to ADDR_W.

## Timing
- Reset: state IDLE, `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=1, `boot_done`=0, `boot_err`=0, checksum 0, counters 0.
- `mem_we` asserts in the cycle after the 4th byte of a word is accepted, for exactly one cycle, with `mem_addr`/`mem_wdata` stable in that cycle.
- Back-to-back byte acceptance sustains one byte/cycle; no bubbles are inserted.
- The final `mem_we` precedes the `cpu_hold` deassertion by at least one cycle. Without the macro, `cpu_hold` falls in the cycle after the final `mem_we`; with it, in the cycle after checksum acceptance.
- `in_valid` low stalls without loss of partial-word state.
- Reset asserted mid-load aborts immediately to reset values; partially written memory is not cleaned.

## Configuration
- `MIPS32_BOOT_CHECKSUM_EN` defined: CHK state present; trailing XOR byte required, and a mismatch → ERR.
- Undefined: no CHK state and no XOR logic; the last payload word goes directly to DONE.

## Test plan
- Reset then `start`, stream length 0x0009 and words 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000 at 1 byte/cycle → 9 `mem_we` pulses at addresses 0..8 with exact data, then `cpu_hold` 1→0 and `boot_done`=1.
- Same image with random `in_valid` gaps → identical write sequence, and no write while a word is partial.
- Checksum on: correct XOR byte → DONE; XOR byte flipped by 0x01 → ERR, `cpu_hold` stays 1, and `in_ready`=0.
- Length 0x0401 with ADDR_W=10 → ERR after LEN_LO, with zero `mem_we` pulses.
- Length 0 → DONE with no writes; `start` in DONE → `cpu_hold`=1 the next cycle, and a reload of 2 words succeeds.
- `rst_n` low after 5 payload bytes → all outputs at reset values asynchronously; a subsequent full load writes from address 0.
